// File: rtl/i2c_master_arbiter_if.sv
// rtl/i2c_master_arbiter_if.sv - command/status bundle between the arbiter and the shared i2c_user_fsm
interface i2c_master_arbiter_if;
  logic [7:0] i2c_slave;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_wdata;
  logic       i2c_write_req;
  logic       i2c_read_req;
  logic       i2c_ready;
  logic [7:0] i2c_rdata;
  logic       i2c_rdata_valid;
  logic       i2c_fail;

  modport master (
    output i2c_slave, i2c_reg_addr, i2c_wdata, i2c_write_req, i2c_read_req,
    input  i2c_ready, i2c_rdata, i2c_rdata_valid, i2c_fail
  );

  modport slave (
    input  i2c_slave, i2c_reg_addr, i2c_wdata, i2c_write_req, i2c_read_req,
    output i2c_ready, i2c_rdata, i2c_rdata_valid, i2c_fail
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin sharing of one i2c_user_fsm among N_REQ requesters
// Optional WAIT_DONE watchdog enabled by I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter #(
  parameter int N_REQ      = 2,
  parameter int START_WAIT = 8
`ifdef I2C_ARB_TIMEOUT_EN
  , parameter logic [31:0] TIMEOUT_CYC = 32'd2000000
`endif
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_rw,
  input  logic [8*N_REQ-1:0]   req_slave,
  input  logic [8*N_REQ-1:0]   req_reg_addr,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_fail,
  output logic                 busy,
  output logic [1:0]           grant_id,
  i2c_master_arbiter_if.master i2c
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  localparam int SW_W = $clog2(START_WAIT + 1);

  state_t          state, state_nxt;
  logic [1:0]      ptr, win;
  logic [2:0]      idx;
  logic            found, grant, set_fail, sw_expire, tmo_expire;
  logic [3:0]      valid4, rw4, rdy4, rv4;
  logic [31:0]     slave4, reg4, wdata4;
  logic            rw_q, fail_q;
  logic [7:0]      rdata_q;
  logic [SW_W-1:0] sw_cnt;

  // Pad request vectors to the 4-requester maximum so indexing is width-uniform.
  assign valid4 = 4'(req_valid);
  assign rw4    = 4'(req_rw);
  assign slave4 = 32'(req_slave);
  assign reg4   = 32'(req_reg_addr);
  assign wdata4 = 32'(req_wdata);

  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(N_REQ)) idx = idx - 3'(N_REQ);
      if (!found && valid4[idx[1:0]]) begin
        found = 1'b1;
        win   = idx[1:0];
      end
    end
  end

  assign grant     = (state == IDLE) && i2c.i2c_ready && found;
  assign sw_expire = (sw_cnt == SW_W'(START_WAIT - 1));

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)              tmo_cnt <= '0;
    else if (state == WAIT_DONE) tmo_cnt <= tmo_cnt + 32'd1;
    else                         tmo_cnt <= '0;
  end
  assign tmo_expire = (tmo_cnt == TIMEOUT_CYC - 32'd1);
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    set_fail  = 1'b0;
    case (state)
      IDLE:      if (grant) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!i2c.i2c_ready) begin
          state_nxt = WAIT_DONE;
        end else if (sw_expire) begin
          set_fail  = 1'b1;
          state_nxt = RESP;
        end
      end
      WAIT_DONE: begin
        if (i2c.i2c_ready) begin
          state_nxt = RESP;
        end else if (tmo_expire) begin
          set_fail  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr              <= '0;
      grant_id         <= '0;
      rw_q             <= 1'b0;
      fail_q           <= 1'b0;
      rdata_q          <= '0;
      sw_cnt           <= '0;
      i2c.i2c_slave    <= '0;
      i2c.i2c_reg_addr <= '0;
      i2c.i2c_wdata    <= '0;
    end else begin
      if (grant) begin
        grant_id         <= win;
        rw_q             <= rw4[win];
        i2c.i2c_slave    <= slave4[{win, 3'b000} +: 8];
        i2c.i2c_reg_addr <= reg4[{win, 3'b000} +: 8];
        i2c.i2c_wdata    <= wdata4[{win, 3'b000} +: 8];
      end
      sw_cnt <= (state == WAIT_BUSY) ? sw_cnt + 1'b1 : '0;
      case (state)
        ISSUE: begin
          fail_q  <= 1'b0;
          rdata_q <= '0;
        end
        WAIT_DONE: begin
          if (i2c.i2c_fail) fail_q <= 1'b1;
          if (i2c.i2c_rdata_valid && rw_q) rdata_q <= i2c.i2c_rdata;
        end
        RESP: ptr <= (grant_id == 2'(N_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
        default: ;
      endcase
      if (set_fail) fail_q <= 1'b1;
    end
  end

  always_comb begin
    rdy4 = '0;
    rv4  = '0;
    if (grant)         rdy4[win]      = 1'b1;
    if (state == RESP) rv4[grant_id]  = 1'b1;
    req_ready = rdy4[N_REQ-1:0];
    rsp_valid = rv4[N_REQ-1:0];
  end

  assign i2c.i2c_write_req = (state == ISSUE) && !rw_q;
  assign i2c.i2c_read_req  = (state == ISSUE) && rw_q;
  assign rsp_rdata         = rdata_q;
  assign rsp_fail          = fail_q;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - directed vector bench for i2c_master_arbiter
module tb_i2c_master_arbiter;
  localparam int N_REQ      = 2;
  localparam int START_WAIT = 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [1:0]        req_valid, req_rw;
  logic [15:0]       req_slave, req_reg_addr, req_wdata;
  logic [1:0]        req_ready, rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_fail, busy;
  logic [1:0]        grant_id;

  i2c_master_arbiter_if i2c_bus ();

  i2c_master_arbiter #(
    .N_REQ(N_REQ), .START_WAIT(START_WAIT)
`ifdef I2C_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(32'd100)
`endif
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_rw(req_rw), .req_slave(req_slave),
    .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fail(rsp_fail), .busy(busy), .grant_id(grant_id), .i2c(i2c_bus.master)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0] id;
    logic       rw;
    logic [7:0] slave, reg_a, wdata;
    int         busy_cyc;
    logic       fail, rdv;
    logic [7:0] rdata, exp_rdata;
    logic       exp_fail;
  } vec_t;

  vec_t vecs [6];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   rr_cnt [2];
  int   exp_ptr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    #2;
    for (int i = 0; i < 2; i++) if (req_ready[i]) rr_cnt[i]++;
  end

  task automatic run_txn(input vec_t v);
    @(negedge sys_clk);
    req_valid[v.id]              = 1'b1;
    req_rw[v.id]                 = v.rw;
    req_slave[8*v.id +: 8]       = v.slave;
    req_reg_addr[8*v.id +: 8]    = v.reg_a;
    req_wdata[8*v.id +: 8]       = v.wdata;
    #1;
    check("grant_ready", 64'(req_ready), 64'(2'b01 << v.id));
    @(negedge sys_clk);
    req_valid = '0;
    #1;
    check("issue_outputs",
          64'({i2c_bus.i2c_write_req, i2c_bus.i2c_read_req, i2c_bus.i2c_slave,
               i2c_bus.i2c_reg_addr, i2c_bus.i2c_wdata, grant_id, req_ready}),
          64'({(v.rw ? 2'b01 : 2'b10), v.slave, v.reg_a, v.wdata, v.id, 2'b00}));
    @(negedge sys_clk);
    check("strobe_one_cycle", 64'({i2c_bus.i2c_write_req, i2c_bus.i2c_read_req}), 64'(0));
    i2c_bus.i2c_ready = 1'b0;
    for (int c = 0; c < v.busy_cyc; c++) begin
      @(negedge sys_clk);
      i2c_bus.i2c_fail        = v.fail && (c == 1);
      i2c_bus.i2c_rdata_valid = v.rdv && (c == v.busy_cyc - 1);
      i2c_bus.i2c_rdata       = v.rdata;
    end
    @(negedge sys_clk);
    i2c_bus.i2c_fail        = 1'b0;
    i2c_bus.i2c_rdata_valid = 1'b0;
    i2c_bus.i2c_ready       = 1'b1;
    #1;
    check("no_early_rsp", 64'(rsp_valid), 64'(0));
    @(negedge sys_clk);
    #1;
    check("rsp", 64'({rsp_valid, rsp_rdata, rsp_fail}),
          64'({(2'b01 << v.id), v.exp_rdata, v.exp_fail}));
    exp_ptr = (v.id == 2'd1) ? 0 : 1;
  endtask

  initial begin
    int k;
    vecs[0] = '{2'd0, 1'b0, 8'h72, 8'h41, 8'h10, 50, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{2'd1, 1'b1, 8'h72, 8'h00, 8'h00,  5, 1'b0, 1'b1, 8'h13, 8'h13, 1'b0};
    vecs[2] = '{2'd0, 1'b0, 8'h39, 8'h10, 8'h55,  4, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{2'd1, 1'b0, 8'h39, 8'h11, 8'h66,  4, 1'b0, 1'b1, 8'hAA, 8'h00, 1'b0};
    vecs[4] = '{2'd0, 1'b1, 8'h50, 8'h20, 8'h00,  3, 1'b1, 1'b1, 8'h5C, 8'h5C, 1'b1};
    vecs[5] = '{2'd1, 1'b1, 8'h50, 8'h21, 8'h00,  2, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0};

    sys_rst_n = 1'b0;
    req_valid = '0; req_rw = '0; req_slave = '0; req_reg_addr = '0; req_wdata = '0;
    i2c_bus.i2c_ready = 1'b1; i2c_bus.i2c_rdata = '0;
    i2c_bus.i2c_rdata_valid = 1'b0; i2c_bus.i2c_fail = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_state",
          64'({busy, grant_id, req_ready, rsp_valid, rsp_rdata, rsp_fail,
               i2c_bus.i2c_write_req, i2c_bus.i2c_read_req, i2c_bus.i2c_slave,
               i2c_bus.i2c_reg_addr, i2c_bus.i2c_wdata}), 64'(0));
    sys_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Both requesters held valid: grants must alternate from the pointer.
    @(negedge sys_clk);
    rr_cnt[0] = 0; rr_cnt[1] = 0;
    req_valid = 2'b11; req_rw = 2'b00;
    for (int t = 0; t < 4; t++) begin
      k = 0;
      #1;
      while (req_ready == 2'b00 && k < 20) begin
        @(negedge sys_clk); #1; k++;
      end
      check("rr_grant", 64'(req_ready), 64'(2'b01 << exp_ptr));
      @(negedge sys_clk);
      @(negedge sys_clk);
      i2c_bus.i2c_ready = 1'b0;
      repeat (3) @(negedge sys_clk);
      i2c_bus.i2c_ready = 1'b1;
      @(negedge sys_clk);
      #1;
      check("rr_rsp", 64'(rsp_valid), 64'(2'b01 << exp_ptr));
      if (t == 3) req_valid = '0;
      exp_ptr = (exp_ptr + 1) % 2;
    end
    @(negedge sys_clk);
    #3;
    check("rr_ready_counts", 64'({rr_cnt[0][7:0], rr_cnt[1][7:0], busy}), 64'({8'd2, 8'd2, 1'b0}));

    // FSM never drops ready: START_WAIT expiry.
    @(negedge sys_clk);
    req_valid[0] = 1'b1; req_rw[0] = 1'b0;
    @(negedge sys_clk);
    req_valid = '0;
    k = 0;
    while (k < 40) begin
      @(negedge sys_clk); #1;
      if (rsp_valid != 2'b00) break;
      k++;
    end
    check("start_wait_cycles", 64'(k), 64'(START_WAIT));
    check("start_wait_rsp", 64'({rsp_valid, rsp_fail}), 64'({2'b01, 1'b1}));
    @(negedge sys_clk);

`ifdef I2C_ARB_TIMEOUT_EN
    req_valid[1] = 1'b1; req_rw[1] = 1'b1;
    @(negedge sys_clk);
    req_valid = '0;
    @(negedge sys_clk);
    i2c_bus.i2c_ready = 1'b0;
    k = 0;
    while (k < 200) begin
      @(negedge sys_clk); #1;
      if (rsp_valid != 2'b00) break;
      k++;
    end
    check("timeout_cycles", 64'(k), 64'(100));
    check("timeout_rsp", 64'({rsp_valid, rsp_fail}), 64'({2'b10, 1'b1}));
    @(negedge sys_clk);
    req_valid[0] = 1'b1; req_rw[0] = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk); #1;
      if (req_ready != 2'b00 || busy) k++;
    end
    check("no_grant_while_hung", 64'(k), 64'(0));
    i2c_bus.i2c_ready = 1'b1;
    #1;
    check("grant_after_ready", 64'(req_ready), 64'(2'b01));
    @(negedge sys_clk);
    req_valid = '0;
    @(negedge sys_clk);
    i2c_bus.i2c_ready = 1'b0;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("reset_mid_done", 64'({busy, rsp_valid}), 64'(0));
    i2c_bus.i2c_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk); #1;
      if (c == 2) sys_rst_n = 1'b1;
      if (rsp_valid != 2'b00) k++;
    end
    check("no_rsp_after_reset", 64'(k), 64'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one i2c_user_fsm master between up to 4 independent requesters, such as the adv7513 configuration sequencer and a camera/status readback engine.
- Performs round-robin arbitration, latches the winning command and issues a single-cycle write/read request to the FSM.
- Tracks the FSM through completion and returns a per-requester response pulse with read data and fail status.
- Sits between the configuration sequencers and the i2c_user_fsm instance.

Parameters:
N_REQ, 2, number of requesters (legal range 2..4).
START_WAIT, 8, cycles allowed after a request for i2c_ready to fall before the transaction is declared failed.
TIMEOUT_CYC, 32'd2000000, cycles allowed in WAIT_DONE (used only when I2C_ARB_TIMEOUT_EN is defined).

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
sys_rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester command valid, held high until accepted
req_rw  in  N_REQ  per-requester direction: 1 = read, 0 = write
req_slave  in  8*N_REQ  packed slave addresses, requester i in [8i+7:8i]
req_reg_addr  in  8*N_REQ  packed register addresses
req_wdata  in  8*N_REQ  packed write data
req_ready  out  N_REQ  one-cycle accept pulse to the granted requester
rsp_valid  out  N_REQ  one-cycle completion pulse to the granted requester
rsp_rdata  out  8  read data, valid when any rsp_valid bit is high
rsp_fail  out  1  failure flag, valid when any rsp_valid bit is high
busy  out  1  high in every state except IDLE
grant_id  out  2  index of the current or last granted requester
i2c_slave  out  8  to FSM: slave address
i2c_reg_addr  out  8  to FSM: register address
i2c_wdata  out  8  to FSM: write data
i2c_write_req  out  1  to FSM: single-cycle write strobe
i2c_read_req  out  1  to FSM: single-cycle read strobe
i2c_ready  in  1  from FSM: idle / operation complete
i2c_rdata  in  8  from FSM: read data
i2c_rdata_valid  in  1  from FSM: read data strobe
i2c_fail  in  1  from FSM: NACK / failure indication

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, round-robin pointer 0, grant_id 0, internal fail and rdata registers 0.
- Arbitration order: search starts at the pointer and wraps modulo N_REQ. Requesters with index >= N_REQ never exist.
- IDLE:
  - Grant only when i2c_ready = 1 and at least one req_valid bit is set.
  - Winner = first set req_valid bit at or after the pointer.
  - On grant: latch the winner's slave, reg_addr, wdata and rw into the i2c_* output registers; set grant_id; pulse req_ready[winner] for that same cycle; go to ISSUE.
- ISSUE (1 cycle): assert exactly one of i2c_write_req or i2c_read_req, selected by the latched rw. Clear the fail register and clear the rdata register to 0. Go to WAIT_BUSY.
- WAIT_BUSY:
  - When i2c_ready = 0, go to WAIT_DONE.
  - If START_WAIT cycles elapse with i2c_ready still 1, set fail and go to RESP.
- WAIT_DONE:
  - On i2c_rdata_valid, capture i2c_rdata (read transactions only).
  - Any cycle with i2c_fail = 1 sets fail; fail is sticky for the rest of the transaction.
  - When i2c_ready = 1, go to RESP.
- RESP (1 cycle): pulse rsp_valid[grant_id]; drive rsp_rdata and rsp_fail. Set pointer = (grant_id + 1) mod N_REQ. Go to IDLE.
- Latency, from req_valid high with the arbiter idle: req_ready in the same cycle, read/write strobe 1 cycle later. Rsp_valid occurs 1 cycle after i2c_ready returns high.
- Requesters drop or change req_valid only after req_ready. A req_valid that deasserts before its grant is simply not granted; no error is raised.
- Simultaneous requests are resolved by the pointer. After requester i is served, requester i+1 has priority, so no requester is starved.
- A requester re-asserting req_valid in the RESP cycle is eligible in the next IDLE cycle.
- Reset asserted mid-transaction returns the arbiter to IDLE immediately and no rsp_valid is generated.
- The i2c_* address and data outputs hold their latched values until the next grant.

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs in WAIT_DONE.
  - On reaching TIMEOUT_CYC: fail = 1, go to RESP.
  - The next grant still waits in IDLE for i2c_ready = 1, so a hung FSM blocks new transactions but does not deadlock requesters that are waiting for a response.
- Undefined: no counter is built, and WAIT_DONE waits indefinitely for i2c_ready.

Test Plan:
- Single write from req 0 (slave 8'h72, reg 8'h41, data 8'h10), FSM model drops ready for 50 cycles:
  -> req_ready[0] in the grant cycle, then a 1-cycle i2c_write_req with outputs 72/41/10.
  -> rsp_valid[0] 1 cycle after ready rises, rsp_fail = 0.
- Read from req 1 (reg 8'h00), FSM returns rdata_valid with 8'h13:
  -> a 1-cycle i2c_read_req, then rsp_valid[1] with rsp_rdata = 8'h13 and rsp_fail = 0.
- req 0 and req 1 both held valid continuously, 4 transactions:
  -> grant order 0, 1, 0, 1; each requester sees exactly one req_ready per grant.
- FSM pulses i2c_fail mid-transaction:
  -> rsp_fail = 1 on the response.
  -> The next transaction has fail cleared and reports rsp_fail = 0.
- FSM never drops ready after the strobe:
  -> rsp_valid with rsp_fail = 1 exactly START_WAIT cycles after WAIT_BUSY is entered.
- With I2C_ARB_TIMEOUT_EN defined and TIMEOUT_CYC = 100, FSM holds ready low forever:
  -> rsp_fail = 1 after 100 cycles in WAIT_DONE.
  -> No further grant occurs while i2c_ready stays 0.
  -> Asserting reset mid-WAIT_DONE clears busy and produces no rsp_valid.
